sram22_req_adapter: RTL and testbench
=====================================

Name: sram22_req_adapter

Overview:
- Front-end controller directly upstream of a single-port sram22 macro (1RW, synchronous read, 1-cycle read latency, no chip-select, dout updated every clock edge).
- Converts a valid/ready request channel into macro port drives.
- Captures macro dout the cycle after each accepted read into a response FIFO, so read data survives consumer backpressure.
- Sits between a bus/DMA client and the macro instance.

Parameters:
- DATA_WIDTH, 8: data bits; equals the macro's DATA_WIDTH.
- ADDR_WIDTH, 9: address bits; equals the macro's ADDR_WIDTH.
- WMASK_WIDTH, 1: write-mask bits; equals the macro's WMASK_WIDTH (DATA_WIDTH/WMASK_WIDTH bits per lane).
- RESP_DEPTH, 4: response FIFO entries; power of two, >=2.

Ports:
- clk  in  1  clock; shared with the macro.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high with req_valid.
- req_we  in  1  1=write, 0=read.
- req_wmask  in  WMASK_WIDTH  per-lane write enable; ignored for reads.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer takes rsp_rdata.
- rsp_rdata  out  DATA_WIDTH  read data, in request order.
- rsp_count  out  $clog2(RESP_DEPTH)+1  FIFO occupancy plus read in flight.
- sram_we  out  1  to macro we.
- sram_wmask  out  WMASK_WIDTH  to macro wmask.
- sram_addr  out  ADDR_WIDTH  to macro addr.
- sram_din  out  DATA_WIDTH  to macro din.
- sram_dout  in  DATA_WIDTH  from macro dout.

Behaviour:
- fire = req_valid & req_ready. rd_fire = fire & ~req_we. wr_fire = fire & req_we.
- Macro drive is combinational:
  - sram_addr = req_addr, sram_din = req_wdata, sram_wmask = req_wmask.
  - sram_we = wr_fire.
  - Idle cycles present a harmless read of req_addr. That result is never captured.
- rd_pend register (reset 0): <= rd_fire.
- Capture: when rd_pend=1, sram_dout is pushed into the FIFO on that cycle's clock edge, i.e. the data of the read accepted in cycle t is pushed at the end of cycle t+1.
- Output timing:
  - rsp_valid rises in cycle t+2 at the earliest. Minimum latency is 2 cycles from fire to rsp_valid.
  - No bypass path.
- Credit rule: rsp_count = fifo_count + rd_pend.
  - req_ready = (rsp_count < RESP_DEPTH). Applies to writes too.
  - Computed from registers only. There is no combinational path from rsp_ready or req_valid to req_ready.
  - A pop in the same cycle frees credit the following cycle.
- Full throughput: back-to-back reads with rsp_ready=1 sustain 1 read/cycle for RESP_DEPTH>=3.
- FIFO:
  - rsp_valid = (fifo_count != 0); rsp_rdata = head entry.
  - Pop when rsp_valid & rsp_ready. Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo RESP_DEPTH.
  - Overflow is impossible by the credit rule. An assertion flags push when full.
- Writes produce no response and do not enter the FIFO.
  - A write in cycle t followed by a read of the same address in t+1 returns the new data (the macro commits the write at the t edge).
- Ordering: responses are strictly in read-acceptance order.
- Reset (async assert, sync deassert externally):
  - rd_pend=0, FIFO pointers/count=0, rsp_valid=0, req_ready=1 (after reset, rsp_count=0).
  - sram_we is 0 during reset (forced, independent of req_valid).
  - Reset mid-operation discards in-flight reads and buffered data. SRAM contents are unaffected.
- FIFO storage needs no reset. rsp_rdata is don't-care while rsp_valid=0.

Decomposition:
- Package sram22_pkg: default DATA_WIDTH/ADDR_WIDTH/WMASK_WIDTH constants for the 512x8m8w8 instance, and a request struct typedef (we, wmask, addr, wdata).
- Sub-module sram22_rsp_fifo: parameterised synchronous FIFO (DEPTH, WIDTH), async active-low reset, push/pop/count/full/empty.
- The adapter holds the credit logic, rd_pend, and macro drive.

Test Plan:
- Reset, then idle 5 cycles with req_valid=0 -> sram_we=0, rsp_valid=0, req_ready=1, rsp_count=0 throughout.
- Write addr 0x1A0 data 0x5C wmask=1, next cycle read 0x1A0 -> sram_we high for exactly one cycle; rsp_valid 2 cycles after the read fire with rsp_rdata=0x5C.
- Backpressure:
  - Stimulus: rsp_ready=0; issue 6 back-to-back reads of addrs 0..5 (preloaded 0x10+addr).
  - Required: req_ready drops after 4 accepted (rsp_count=4).
  - Then rsp_ready=1: data 0x10..0x13 drain in order, followed by 0x14, 0x15, with no loss or duplication.
- Streaming with rsp_ready=1: 100 consecutive reads -> one fire per cycle after the first, responses in order, rsp_count never exceeds 2.
- Write with wmask=0 to addr 7 (holding 0xAA), then read 7 -> rsp_rdata=0xAA.
- Assert rst_n=0 with 2 entries buffered and 1 read pending -> rsp_valid=0 immediately; after release, rsp_count=0 and a read of a previously written address returns the stored value.

Source files
------------

// File: rtl/sram22_pkg.sv
// Shared constants and types for the sram22 request adapter.
//
// The default widths match the 512x8 sram22 instance with a single write lane.
// sram22_req_t bundles one request beat at those default widths. The bench uses
// it to build compact stimulus tables.
package sram22_pkg;

  localparam int SRAM22_DATA_WIDTH  = 8;
  localparam int SRAM22_ADDR_WIDTH  = 9;
  localparam int SRAM22_WMASK_WIDTH = 1;

  typedef struct packed {
    logic                          we;
    logic [SRAM22_WMASK_WIDTH-1:0] wmask;
    logic [SRAM22_ADDR_WIDTH-1:0]  addr;
    logic [SRAM22_DATA_WIDTH-1:0]  wdata;
  } sram22_req_t;

endpackage

// File: rtl/sram22_rsp_fifo.sv
// Synchronous FIFO that buffers read responses.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (clears pointers/count only)
//   push        write push_data at the tail (ignored when full)
//   push_data   entry to write
//   pop         drop the head entry (ignored when empty)
//   pop_data    head entry (don't-care while empty)
//   count       occupancy, 0..DEPTH
//   full        count == DEPTH
//   empty       count == 0
// DEPTH must be a power of two so that the pointers wrap naturally.
module sram22_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_next;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // NOTE: storage has no reset; validity is tracked by count alone, so the
  // array can map to plain flops/RAM without a reset network.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // NOTE: count_next gets a default first so no path leaves it unassigned,
  // which would infer a latch.
  always_comb begin
    count_next = count;
    unique case ({do_push, do_pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

endmodule

// File: rtl/sram22_req_adapter.sv
// Request-channel front end for a single-port sram22 macro (1RW, 1-cycle read).
//
// Ports:
//   clk, rst_n            clock shared with the macro, async active-low reset
//   req_valid/req_ready   request handshake (req_ready depends on registers only)
//   req_we, req_wmask,
//   req_addr, req_wdata   request fields (wmask ignored for reads)
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata             read data, in request order
//   rsp_count             buffered responses plus the read in flight
//   sram_we, sram_wmask,
//   sram_addr, sram_din   combinational macro drive
//   sram_dout             macro read data, valid the cycle after the read
//
// The macro drive is taken straight from the request bus. An idle cycle therefore
// performs a harmless read whose result is never captured. A read accepted in
// cycle t sets rd_pend for cycle t+1, and sram_dout is pushed into the FIFO at
// the end of t+1. Reads hold a FIFO slot (credit) from acceptance, so the FIFO
// cannot overflow.
module sram22_req_adapter
  import sram22_pkg::*;
#(
  parameter int DATA_WIDTH  = SRAM22_DATA_WIDTH,
  parameter int ADDR_WIDTH  = SRAM22_ADDR_WIDTH,
  parameter int WMASK_WIDTH = SRAM22_WMASK_WIDTH,
  parameter int RESP_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic [WMASK_WIDTH-1:0]        req_wmask,
  input  logic [ADDR_WIDTH-1:0]         req_addr,
  input  logic [DATA_WIDTH-1:0]         req_wdata,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic [$clog2(RESP_DEPTH):0]   rsp_count,
  output logic                          sram_we,
  output logic [WMASK_WIDTH-1:0]        sram_wmask,
  output logic [ADDR_WIDTH-1:0]         sram_addr,
  output logic [DATA_WIDTH-1:0]         sram_din,
  input  logic [DATA_WIDTH-1:0]         sram_dout
);

  localparam int CW = $clog2(RESP_DEPTH) + 1;

  logic          fire;
  logic          rd_fire;
  logic          wr_fire;
  logic          rd_pend;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;

  // Credit counts the read in flight so that its FIFO slot is reserved at accept.
  assign rsp_count = fifo_count + CW'(rd_pend);
  assign req_ready = (rsp_count < CW'(RESP_DEPTH));

  assign fire    = req_valid & req_ready;
  assign rd_fire = fire & ~req_we;
  assign wr_fire = fire & req_we;

  // Gating with rst_n keeps the macro from being written while reset is held,
  // whatever the client drives.
  assign sram_we    = wr_fire & rst_n;
  assign sram_wmask = req_wmask;
  assign sram_addr  = req_addr;
  assign sram_din   = req_wdata;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= rd_fire;
    end
  end

  sram22_rsp_fifo #(
    .DEPTH (RESP_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_pend),
    .push_data (sram_dout),
    .pop       (rsp_ready),
    .pop_data  (rsp_rdata),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rsp_valid = ~fifo_empty;

  // A capture into a full FIFO would mean the credit accounting is broken.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) rd_pend |-> !fifo_full);

endmodule

// File: tb/tb_sram22_req_adapter.sv
// Self-checking bench for sram22_req_adapter.
// A behavioural macro model drives sram_dout. A separate shadow memory and a
// queue of outstanding reads supply every expected value.
module tb_sram22_req_adapter;
  import sram22_pkg::*;

  localparam int DW    = SRAM22_DATA_WIDTH;
  localparam int AW    = SRAM22_ADDR_WIDTH;
  localparam int MW    = SRAM22_WMASK_WIDTH;
  localparam int LANE  = DW / MW;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [MW-1:0] req_wmask;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [CW-1:0] rsp_count;
  logic          sram_we;
  logic [MW-1:0] sram_wmask;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout;

  sram22_req_adapter #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .WMASK_WIDTH (MW),
    .RESP_DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_wmask  (req_wmask),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_count  (rsp_count),
    .sram_we    (sram_we),
    .sram_wmask (sram_wmask),
    .sram_addr  (sram_addr),
    .sram_din   (sram_din),
    .sram_dout  (sram_dout)
  );

  always #5 clk = ~clk;

  // Macro model: 1RW, synchronous read, dout refreshed on every edge.
  logic [DW-1:0] macro_mem [2**AW];
  always @(posedge clk) begin
    if (sram_we) begin
      for (int l = 0; l < MW; l++) begin
        if (sram_wmask[l]) macro_mem[sram_addr][l*LANE +: LANE] <= sram_din[l*LANE +: LANE];
      end
    end
    sram_dout <= macro_mem[sram_addr];
  end

  // Reference: shadow memory plus the list of accepted, not yet consumed reads.
  typedef struct {
    logic [DW-1:0] data;
    int            fire_cyc;
  } pend_t;

  logic [DW-1:0] ref_mem [2**AW];
  pend_t         exp_q[$];
  logic [DW-1:0] got_q[$];
  logic          log_en;
  int            cyc;
  int            max_count;
  int            n_checks;
  int            n_errors;

  typedef struct {
    logic          v;
    sram22_req_t   r;
    logic          rr;
    logic          exp_we;
    logic          exp_valid;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic sram22_req_t mk(input logic we, input logic [MW-1:0] m,
                                     input logic [AW-1:0] a, input logic [DW-1:0] d);
    sram22_req_t r;
    r.we = we; r.wmask = m; r.addr = a; r.wdata = d;
    return r;
  endfunction

  // One clock cycle: drive, check against the reference mid-cycle, update it at the edge.
  task automatic step(input sram22_req_t r, input logic v, input logic rr, output logic fired,
                      output logic s_we, output logic s_valid, output logic [DW-1:0] s_rdata);
    logic exp_ready;
    logic exp_valid;
    logic pop;
    req_valid = v;
    req_we    = r.we;
    req_wmask = r.wmask;
    req_addr  = r.addr;
    req_wdata = r.wdata;
    rsp_ready = rr;
    @(negedge clk);
    exp_ready = (exp_q.size() < DEPTH);
    exp_valid = (exp_q.size() != 0) && (cyc >= exp_q[0].fire_cyc + 2);
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("rsp_count", 32'(rsp_count), 32'(exp_q.size()));
    check("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
    if (exp_valid) check("rsp_rdata", 32'(rsp_rdata), 32'(exp_q[0].data));
    check("sram_we", 32'(sram_we), 32'(v & r.we & exp_ready));
    check("sram_addr", 32'(sram_addr), 32'(r.addr));
    if (v && r.we) begin
      check("sram_din", 32'(sram_din), 32'(r.wdata));
      check("sram_wmask", 32'(sram_wmask), 32'(r.wmask));
    end
    if (32'(rsp_count) > max_count) max_count = 32'(rsp_count);
    s_we    = sram_we;
    s_valid = rsp_valid;
    s_rdata = rsp_rdata;
    pop     = exp_valid & rr;
    if (pop && log_en) got_q.push_back(rsp_rdata);
    fired = v & exp_ready;
    @(posedge clk);
    if (pop) void'(exp_q.pop_front());
    if (fired && r.we) begin
      for (int l = 0; l < MW; l++) begin
        if (r.wmask[l]) ref_mem[r.addr][l*LANE +: LANE] = r.wdata[l*LANE +: LANE];
      end
    end else if (fired) begin
      exp_q.push_back('{ref_mem[r.addr], cyc});
    end
    cyc++;
    #1;
  endtask

  task automatic run(input sram22_req_t r, input logic v, input logic rr, output logic fired);
    logic          s_we;
    logic          s_valid;
    logic [DW-1:0] s_rdata;
    step(r, v, rr, fired, s_we, s_valid, s_rdata);
  endtask

  task automatic drain();
    logic f;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) run(mk(0, '0, '0, '0), 1'b0, 1'b1, f);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    vec_t          vecs[10];
    logic          f;
    logic          s_we;
    logic          s_valid;
    logic [DW-1:0] s_rdata;
    int            accepted;
    int            n_fire;

    clk = 1'b0; rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_wmask = '0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    cyc = 0; max_count = 0; n_checks = 0; n_errors = 0; log_en = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Idle after reset.
    for (int i = 0; i < 5; i++) run(mk(0, '0, AW'(i * 37), '0), 1'b0, 1'b0, f);

    // Preload addresses 0..15 through the adapter.
    for (int a = 0; a < 16; a++) begin
      logic [DW-1:0] d;
      d = (a < 6) ? DW'(8'h10 + a) : (a == 7) ? 8'hAA : DW'(8'h40 + a * 3);
      run(mk(1, '1, AW'(a), d), 1'b1, 1'b1, f);
    end
    drain();

    // Directed table: write-then-read forwarding and a masked-off write.
    vecs[0] = '{1, mk(1, 1'b1, 9'h1A0, 8'h5C), 1, 1, 0, 8'h00};
    vecs[1] = '{1, mk(0, 1'b0, 9'h1A0, 8'h00), 1, 0, 0, 8'h00};
    vecs[2] = '{0, mk(0, 1'b0, 9'h000, 8'h00), 1, 0, 0, 8'h00};
    vecs[3] = '{0, mk(0, 1'b0, 9'h000, 8'h00), 1, 0, 1, 8'h5C};
    vecs[4] = '{0, mk(0, 1'b0, 9'h000, 8'h00), 1, 0, 0, 8'h00};
    vecs[5] = '{1, mk(1, 1'b0, 9'h007, 8'h55), 1, 1, 0, 8'h00};
    vecs[6] = '{1, mk(0, 1'b0, 9'h007, 8'h00), 1, 0, 0, 8'h00};
    vecs[7] = '{0, mk(0, 1'b0, 9'h000, 8'h00), 1, 0, 0, 8'h00};
    vecs[8] = '{0, mk(0, 1'b0, 9'h000, 8'h00), 1, 0, 1, 8'hAA};
    vecs[9] = '{0, mk(0, 1'b0, 9'h000, 8'h00), 1, 0, 0, 8'h00};
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].r, vecs[i].v, vecs[i].rr, f, s_we, s_valid, s_rdata);
      check($sformatf("vec%0d_we", i), 32'(s_we), 32'(vecs[i].exp_we));
      check($sformatf("vec%0d_valid", i), 32'(s_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) check($sformatf("vec%0d_rdata", i), 32'(s_rdata), 32'(vecs[i].exp_rdata));
    end

    // Backpressure: six reads with the consumer stalled, then release.
    got_q.delete();
    log_en   = 1'b1;
    accepted = 0;
    for (int k = 0; k < 8; k++) begin
      run(mk(0, '0, AW'(accepted), '0), 1'b1, 1'b0, f);
      if (f) accepted++;
    end
    check("bp_accepted_stalled", 32'(accepted), 32'd4);
    for (int k = 0; k < 30 && (accepted < 6 || exp_q.size() != 0); k++) begin
      run(mk(0, '0, AW'(accepted), '0), accepted < 6, 1'b1, f);
      if (f) accepted++;
    end
    check("bp_accepted_total", 32'(accepted), 32'd6);
    check("bp_rsp_total", 32'(got_q.size()), 32'd6);
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      check($sformatf("bp_order%0d", i), 32'(got_q[i]), 32'h10 + 32'(i));
    end
    log_en = 1'b0;

    // Streaming: one read per cycle with the consumer always ready.
    max_count = 0;
    n_fire    = 0;
    for (int i = 0; i < 100; i++) begin
      run(mk(0, '0, AW'($urandom_range(0, 15)), '0), 1'b1, 1'b1, f);
      if (f) n_fire++;
    end
    check("stream_fires", 32'(n_fire), 32'd100);
    check("stream_max_count_le2", 32'(max_count <= 2), 32'd1);
    drain();

    // Randomised traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      run(mk($urandom_range(0, 2) == 0, MW'($urandom), AW'($urandom_range(0, 15)), DW'($urandom)),
          $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, f);
    end
    drain();

    // Reset with two buffered responses and one read in flight.
    for (int i = 1; i <= 3; i++) run(mk(0, '0, AW'(i), '0), 1'b1, 1'b0, f);
    req_valid = 1'b1; req_we = 1'b1; req_wmask = '1; req_addr = 9'h1A0; req_wdata = 8'hFF;
    rst_n = 1'b0;
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_count", 32'(rsp_count), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_sram_we", 32'(sram_we), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n     = 1'b1;
    @(posedge clk); #1;
    check("post_rst_count", 32'(rsp_count), 32'd0);
    got_q.delete();
    log_en = 1'b1;
    run(mk(0, '0, 9'h1A0, '0), 1'b1, 1'b1, f);
    drain();
    check("post_rst_rsp_total", 32'(got_q.size()), 32'd1);
    if (got_q.size() != 0) check("post_rst_rdata", 32'(got_q[0]), 32'h5C);
    log_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
